// File: rtl/sirv_repeater_param_pkg.sv
// sirv_repeater_param_pkg: shared TileLink field widths, opcodes and repeat-mode encoding
package sirv_repeater_param_pkg;
  localparam int TL_OPCODE_W = 3;
  localparam int TL_PARAM_W = 3;
  localparam int TL_SIZE_W = 3;
  localparam int TL_SOURCE_W = 2;
  localparam int TL_ADDR_W = 30;
  localparam int TL_MASK_W = 1;
  localparam int TL_DATA_W = 8;
  localparam int TL_CNT_W = 4;
  localparam logic [2:0] TL_GET = 3'd4;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  typedef enum logic {MODE_LEVEL, MODE_COUNT} repeat_mode_e;
endpackage

// File: rtl/sirv_repeater_param_ctrl.sv
// sirv_repeater_param_ctrl: full flag, remaining-repeat counter and save decision
module sirv_repeater_param_ctrl
  import sirv_repeater_param_pkg::*;
#(
  parameter int CNT_W = TL_CNT_W,
  parameter repeat_mode_e MODE = MODE_LEVEL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             repeat_en,
  input  logic [CNT_W-1:0] repeat_num,
  input  logic             enq_fire,
  input  logic             deq_fire,
  output logic             save,
  output logic             full,
  output logic [CNT_W-1:0] rep_left
);
  assign save = enq_fire & (MODE == MODE_COUNT ? |repeat_num : repeat_en);
  // count mode loads the counter on save and counts down per deq beat; level mode follows repeat_en
  always_ff @(posedge clock)
    if (reset) begin
      full <= 1'b0;
      rep_left <= '0;
    end else if (MODE == MODE_COUNT) begin
      if (save) begin
        full <= 1'b1;
        rep_left <= repeat_num;
      end else if (deq_fire && full) begin
        full <= rep_left != CNT_W'(1);
        rep_left <= rep_left - CNT_W'(1);
      end
    end else
      full <= (deq_fire && !repeat_en) ? 1'b0 : save | full;
endmodule

// File: rtl/sirv_repeater_param.sv
// sirv_repeater_param: TileLink A-channel beat repeater, level or count mode; SIRV_REPEATER_ADDR_INC_EN advances the saved address per beat
module sirv_repeater_param
  import sirv_repeater_param_pkg::*;
#(
  parameter int OPCODE_W = TL_OPCODE_W,
  parameter int PARAM_W = TL_PARAM_W,
  parameter int SIZE_W = TL_SIZE_W,
  parameter int SOURCE_W = TL_SOURCE_W,
  parameter int ADDR_W = TL_ADDR_W,
  parameter int MASK_W = TL_MASK_W,
  parameter int DATA_W = TL_DATA_W,
  parameter int CNT_W = TL_CNT_W,
  parameter int COUNT_MODE = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                repeat_en,
  input  logic [CNT_W-1:0]    repeat_num,
  output logic                full,
  output logic [CNT_W-1:0]    rep_left,
  output logic                enq_ready,
  input  logic                enq_valid,
  input  logic [OPCODE_W-1:0] enq_bits_opcode,
  input  logic [PARAM_W-1:0]  enq_bits_param,
  input  logic [SIZE_W-1:0]   enq_bits_size,
  input  logic [SOURCE_W-1:0] enq_bits_source,
  input  logic [ADDR_W-1:0]   enq_bits_address,
  input  logic [MASK_W-1:0]   enq_bits_mask,
  input  logic [DATA_W-1:0]   enq_bits_data,
  input  logic                deq_ready,
  output logic                deq_valid,
  output logic [OPCODE_W-1:0] deq_bits_opcode,
  output logic [PARAM_W-1:0]  deq_bits_param,
  output logic [SIZE_W-1:0]   deq_bits_size,
  output logic [SOURCE_W-1:0] deq_bits_source,
  output logic [ADDR_W-1:0]   deq_bits_address,
  output logic [MASK_W-1:0]   deq_bits_mask,
  output logic [DATA_W-1:0]   deq_bits_data
);
  localparam repeat_mode_e MODE = COUNT_MODE != 0 ? MODE_COUNT : MODE_LEVEL;
  logic save, enq_fire, deq_fire;
  logic [OPCODE_W-1:0] s_opcode;
  logic [PARAM_W-1:0] s_param;
  logic [SIZE_W-1:0] s_size;
  logic [SOURCE_W-1:0] s_source;
  logic [ADDR_W-1:0] s_address;
  logic [MASK_W-1:0] s_mask;
  logic [DATA_W-1:0] s_data;
  assign enq_ready = deq_ready & ~full;
  assign deq_valid = enq_valid | full;
  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;
  assign deq_bits_opcode = full ? s_opcode : enq_bits_opcode;
  assign deq_bits_param = full ? s_param : enq_bits_param;
  assign deq_bits_size = full ? s_size : enq_bits_size;
  assign deq_bits_source = full ? s_source : enq_bits_source;
  assign deq_bits_address = full ? s_address : enq_bits_address;
  assign deq_bits_mask = full ? s_mask : enq_bits_mask;
  assign deq_bits_data = full ? s_data : enq_bits_data;
  sirv_repeater_param_ctrl #(.CNT_W(CNT_W), .MODE(MODE)) u_ctrl (
    .clock(clock),
    .reset(reset),
    .repeat_en(repeat_en),
    .repeat_num(repeat_num),
    .enq_fire(enq_fire),
    .deq_fire(deq_fire),
    .save(save),
    .full(full),
    .rep_left(rep_left)
  );
  // capture the non-address payload of the beat being saved
  always_ff @(posedge clock)
    if (reset)
      {s_opcode, s_param, s_size, s_source, s_mask, s_data} <= '0;
    else if (save)
      {s_opcode, s_param, s_size, s_source, s_mask, s_data} <=
        {enq_bits_opcode, enq_bits_param, enq_bits_size, enq_bits_source, enq_bits_mask, enq_bits_data};
`ifdef SIRV_REPEATER_ADDR_INC_EN
  // saved address always points at the next beat: one size-step past what was last presented
  always_ff @(posedge clock)
    if (reset)
      s_address <= '0;
    else if (save)
      s_address <= enq_bits_address + (ADDR_W'(1) << enq_bits_size);
    else if (deq_fire && full)
      s_address <= s_address + (ADDR_W'(1) << s_size);
`else
  // saved address is held constant for a plain repeat
  always_ff @(posedge clock)
    if (reset)
      s_address <= '0;
    else if (save)
      s_address <= enq_bits_address;
`endif
endmodule

// File: tb/tb_sirv_repeater_param.sv
// tb_sirv_repeater_param: level-mode and count-mode repeaters checked against a beat-queue reference model
module tb_sirv_repeater_param;
  logic clock = 0, reset = 1;
  logic repeat_en = 0, enq_valid = 0, deq_ready = 0;
  logic [3:0] repeat_num = 0;
  logic [49:0] enq = '0;
  logic full_l, rdy_l, dv_l, full_c, rdy_c, dv_c;
  logic [3:0] rl_l, rl_c;
  logic [49:0] deq_l, deq_c;
  logic [56:0] obs_l, obs_c;
  int checks = 0, errors = 0;
  logic hold = 0;
  logic [49:0] held = '0;
  logic [49:0] q[$];
  always #5 clock = ~clock;
  assign obs_l = {full_l, rl_l, rdy_l, dv_l, deq_l};
  assign obs_c = {full_c, rl_c, rdy_c, dv_c, deq_c};
  sirv_repeater_param #(.COUNT_MODE(0)) dut_l (
    .clock(clock), .reset(reset), .repeat_en(repeat_en), .repeat_num(repeat_num),
    .full(full_l), .rep_left(rl_l), .enq_ready(rdy_l), .enq_valid(enq_valid),
    .enq_bits_opcode(enq[49:47]), .enq_bits_param(enq[46:44]), .enq_bits_size(enq[43:41]),
    .enq_bits_source(enq[40:39]), .enq_bits_address(enq[38:9]), .enq_bits_mask(enq[8:8]),
    .enq_bits_data(enq[7:0]), .deq_ready(deq_ready), .deq_valid(dv_l),
    .deq_bits_opcode(deq_l[49:47]), .deq_bits_param(deq_l[46:44]), .deq_bits_size(deq_l[43:41]),
    .deq_bits_source(deq_l[40:39]), .deq_bits_address(deq_l[38:9]), .deq_bits_mask(deq_l[8:8]),
    .deq_bits_data(deq_l[7:0])
  );
  sirv_repeater_param #(.COUNT_MODE(1)) dut_c (
    .clock(clock), .reset(reset), .repeat_en(repeat_en), .repeat_num(repeat_num),
    .full(full_c), .rep_left(rl_c), .enq_ready(rdy_c), .enq_valid(enq_valid),
    .enq_bits_opcode(enq[49:47]), .enq_bits_param(enq[46:44]), .enq_bits_size(enq[43:41]),
    .enq_bits_source(enq[40:39]), .enq_bits_address(enq[38:9]), .enq_bits_mask(enq[8:8]),
    .enq_bits_data(enq[7:0]), .deq_ready(deq_ready), .deq_valid(dv_c),
    .deq_bits_opcode(deq_c[49:47]), .deq_bits_param(deq_c[46:44]), .deq_bits_size(deq_c[43:41]),
    .deq_bits_source(deq_c[40:39]), .deq_bits_address(deq_c[38:9]), .deq_bits_mask(deq_c[8:8]),
    .deq_bits_data(deq_c[7:0])
  );
  function automatic logic [49:0] adv(input logic [49:0] b);
    logic [49:0] r = b;
`ifdef SIRV_REPEATER_ADDR_INC_EN
    r[38:9] = b[38:9] + (30'd1 << b[43:41]);
`endif
    return r;
  endfunction
  function automatic logic [29:0] addr_at(input logic [29:0] base, input logic [2:0] s, input int k);
`ifdef SIRV_REPEATER_ADDR_INC_EN
    return base + 30'(k) * (30'd1 << s);
`else
    return base + 30'(0 * k + 0 * s);
`endif
  endfunction
  function automatic logic [49:0] rnd_beat(input logic [29:0] a, input logic [2:0] s);
    return {3'($urandom), 3'($urandom), s, 2'($urandom), a, 1'($urandom), 8'($urandom)};
  endfunction
  function automatic logic [56:0] exp_l();
    return {hold, 4'd0, hold ? 1'b0 : deq_ready, hold | enq_valid, hold ? held : enq};
  endfunction
  function automatic logic [56:0] exp_c();
    logic ne = q.size() != 0;
    return {ne, 4'(q.size()), ne ? 1'b0 : deq_ready, ne | enq_valid, ne ? q[0] : enq};
  endfunction
  task automatic model_tick();
    logic [49:0] b;
    if (reset) begin
      hold = 0;
      q.delete();
    end else begin
      if (hold) begin
        if (deq_ready) begin
          if (!repeat_en) hold = 0;
          else held = adv(held);
        end
      end else if (enq_valid && deq_ready && repeat_en) begin
        hold = 1;
        held = adv(enq);
      end
      if (q.size() != 0) begin
        if (deq_ready) void'(q.pop_front());
      end else if (enq_valid && deq_ready && repeat_num != 0) begin
        b = enq;
        for (int k = 0; k < int'(repeat_num); k++) begin
          b = adv(b);
          q.push_back(b);
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clock);
    model_tick();
    @(negedge clock);
  endtask
  task automatic do_reset();
    reset = 1;
    enq_valid = 0;
    tick();
    reset = 0;
  endtask
  task automatic test_reset();
    reset = 1; enq = rnd_beat(30'($urandom), 3'($urandom));
    enq_valid = 1; deq_ready = 1; repeat_en = 1; repeat_num = 4'd5;
    tick(); tick();
    #1;
    checks += 6;
    if (full_l !== 1'b0) begin errors++; $display("FAIL reset_full_l got=%b want=0", full_l); end
    if (full_c !== 1'b0) begin errors++; $display("FAIL reset_full_c got=%b want=0", full_c); end
    if (rl_c !== 4'd0) begin errors++; $display("FAIL reset_rep_left got=%0d want=0", rl_c); end
    if (deq_c !== enq) begin errors++; $display("FAIL reset_mirror got=%h want=%h", deq_c, enq); end
    if (obs_l !== exp_l()) begin errors++; $display("FAIL reset_model_l got=%h want=%h", obs_l, exp_l()); end
    if (obs_c !== exp_c()) begin errors++; $display("FAIL reset_model_c got=%h want=%h", obs_c, exp_c()); end
    reset = 0; enq_valid = 0;
    tick();
  endtask
  task automatic test_level();
    do_reset();
    repeat_num = 0; repeat_en = 1; deq_ready = 1; enq_valid = 1;
    enq = rnd_beat(30'h100, 3'd2);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) repeat_en = 0;
      #1;
      checks += 4;
      if (deq_l[38:9] !== addr_at(30'h100, 3'd2, k) || dv_l !== 1'b1) begin
        errors++; $display("FAIL level_beat%0d got=%h/%b want=%h/1", k, deq_l[38:9], dv_l, addr_at(30'h100, 3'd2, k));
      end
      if (full_l !== (k != 0)) begin errors++; $display("FAIL level_full%0d got=%b want=%b", k, full_l, k != 0); end
      if (obs_l !== exp_l()) begin errors++; $display("FAIL level_model_l%0d got=%h want=%h", k, obs_l, exp_l()); end
      if (obs_c !== exp_c()) begin errors++; $display("FAIL level_model_c%0d got=%h want=%h", k, obs_c, exp_c()); end
      tick();
      enq_valid = 0; enq = rnd_beat(30'($urandom), 3'($urandom));
    end
    enq_valid = 1; deq_ready = 1'($urandom); enq = rnd_beat(30'($urandom), 3'($urandom));
    #1;
    checks += 4;
    if (full_l !== 1'b0) begin errors++; $display("FAIL level_clear got=%b want=0", full_l); end
    if (rdy_l !== deq_ready) begin errors++; $display("FAIL level_ready got=%b want=%b", rdy_l, deq_ready); end
    if (deq_l !== enq) begin errors++; $display("FAIL level_pass got=%h want=%h", deq_l, enq); end
    if (obs_l !== exp_l()) begin errors++; $display("FAIL level_model_end got=%h want=%h", obs_l, exp_l()); end
    tick();
    enq_valid = 0;
  endtask
  task automatic test_count();
    logic [29:0] a = 30'($urandom);
    logic [2:0] s = 3'($urandom);
    do_reset();
    repeat_en = 0; repeat_num = 4'd3; deq_ready = 1; enq_valid = 1;
    enq = rnd_beat(a, s);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks += 4;
      if (rl_c !== (k == 0 ? 4'd0 : 4'(4 - k)) || full_c !== (k > 0 && k < 4)) begin
        errors++; $display("FAIL count_state%0d got=%0d/%b want=%0d/%b", k, rl_c, full_c, k == 0 ? 0 : 4 - k, k > 0 && k < 4);
      end
      if (k < 4 && (deq_c[38:9] !== addr_at(a, s, k) || dv_c !== 1'b1)) begin
        errors++; $display("FAIL count_beat%0d got=%h want=%h", k, deq_c[38:9], addr_at(a, s, k));
      end
      if (obs_l !== exp_l()) begin errors++; $display("FAIL count_model_l%0d got=%h want=%h", k, obs_l, exp_l()); end
      if (obs_c !== exp_c()) begin errors++; $display("FAIL count_model_c%0d got=%h want=%h", k, obs_c, exp_c()); end
      tick();
      enq = rnd_beat(30'($urandom), 3'($urandom)); repeat_num = 4'($urandom);
    end
    enq_valid = 0;
  endtask
  task automatic test_backpressure();
    logic [49:0] b = rnd_beat(30'($urandom), 3'($urandom));
    do_reset();
    repeat_en = 1; repeat_num = 4'd2; deq_ready = 1; enq_valid = 1; enq = b;
    tick();
    deq_ready = 0; enq = rnd_beat(30'($urandom), 3'($urandom));
    for (int k = 0; k < 5; k++) begin
      #1;
      checks += 5;
      if (rl_c !== 4'd2 || full_c !== 1'b1) begin errors++; $display("FAIL bp_rep%0d got=%0d/%b want=2/1", k, rl_c, full_c); end
      if (deq_c !== adv(b) || deq_l !== adv(b)) begin errors++; $display("FAIL bp_bits%0d got=%h/%h want=%h", k, deq_c, deq_l, adv(b)); end
      if (rdy_c !== 1'b0 || rdy_l !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%b/%b want=0", k, rdy_c, rdy_l); end
      if (obs_l !== exp_l()) begin errors++; $display("FAIL bp_model_l%0d got=%h want=%h", k, obs_l, exp_l()); end
      if (obs_c !== exp_c()) begin errors++; $display("FAIL bp_model_c%0d got=%h want=%h", k, obs_c, exp_c()); end
      tick();
    end
    deq_ready = 1; enq_valid = 0; repeat_en = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks += 2;
      if (obs_l !== exp_l()) begin errors++; $display("FAIL bp_drain_l%0d got=%h want=%h", k, obs_l, exp_l()); end
      if (obs_c !== exp_c()) begin errors++; $display("FAIL bp_drain_c%0d got=%h want=%h", k, obs_c, exp_c()); end
      tick();
    end
  endtask
  task automatic test_addr_inc();
    logic [29:0] w1[4] = '{30'h1000, 30'h1004, 30'h1008, 30'h100C};
    logic [29:0] w2[2] = '{30'h3FFFFFFC, 30'h0};
    do_reset();
    repeat_en = 0; repeat_num = 4'd3; deq_ready = 1; enq_valid = 1;
    enq = rnd_beat(30'h1000, 3'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks += 2;
`ifdef SIRV_REPEATER_ADDR_INC_EN
      if (deq_c[38:9] !== w1[k]) begin errors++; $display("FAIL inc_beat%0d got=%h want=%h", k, deq_c[38:9], w1[k]); end
`else
      if (deq_c[38:9] !== w1[0]) begin errors++; $display("FAIL inc_beat%0d got=%h want=%h", k, deq_c[38:9], w1[0]); end
`endif
      if (obs_c !== exp_c()) begin errors++; $display("FAIL inc_model%0d got=%h want=%h", k, obs_c, exp_c()); end
      tick();
      enq_valid = 0;
    end
    repeat_num = 4'd1; enq_valid = 1; enq = rnd_beat(30'h3FFFFFFC, 3'd2);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks += 2;
`ifdef SIRV_REPEATER_ADDR_INC_EN
      if (deq_c[38:9] !== w2[k]) begin errors++; $display("FAIL wrap_beat%0d got=%h want=%h", k, deq_c[38:9], w2[k]); end
`else
      if (deq_c[38:9] !== w2[0]) begin errors++; $display("FAIL wrap_beat%0d got=%h want=%h", k, deq_c[38:9], w2[0]); end
`endif
      if (obs_c !== exp_c()) begin errors++; $display("FAIL wrap_model%0d got=%h want=%h", k, obs_c, exp_c()); end
      tick();
      enq_valid = 0;
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    repeat_en = 1; repeat_num = 4'd3; deq_ready = 1; enq_valid = 1;
    enq = rnd_beat(30'($urandom), 3'($urandom));
    tick();
    enq_valid = 0;
    tick();
    #1;
    checks++;
    if (rl_c !== 4'd2) begin errors++; $display("FAIL mid_pre got=%0d want=2", rl_c); end
    reset = 1;
    tick();
    reset = 0; enq_valid = 1; deq_ready = 1'($urandom); enq = rnd_beat(30'($urandom), 3'($urandom));
    #1;
    checks += 5;
    if (full_c !== 1'b0 || rl_c !== 4'd0) begin errors++; $display("FAIL mid_state got=%b/%0d want=0/0", full_c, rl_c); end
    if (deq_c !== enq || deq_l !== enq) begin errors++; $display("FAIL mid_mirror got=%h/%h want=%h", deq_c, deq_l, enq); end
    if (rdy_c !== deq_ready) begin errors++; $display("FAIL mid_ready got=%b want=%b", rdy_c, deq_ready); end
    if (obs_l !== exp_l()) begin errors++; $display("FAIL mid_model_l got=%h want=%h", obs_l, exp_l()); end
    if (obs_c !== exp_c()) begin errors++; $display("FAIL mid_model_c got=%h want=%h", obs_c, exp_c()); end
    tick();
    enq_valid = 0;
  endtask
  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(0, 99) == 0;
      enq_valid = $urandom_range(0, 3) != 0;
      deq_ready = $urandom_range(0, 3) != 0;
      repeat_en = $urandom_range(0, 2) != 0;
      repeat_num = 4'($urandom_range(0, 4));
      enq = rnd_beat(30'($urandom), 3'($urandom));
      #1;
      checks += 2;
      if (obs_l !== exp_l()) begin errors++; $display("FAIL rand_l%0d got=%h want=%h", k, obs_l, exp_l()); end
      if (obs_c !== exp_c()) begin errors++; $display("FAIL rand_c%0d got=%h want=%h", k, obs_c, exp_c()); end
      tick();
    end
    reset = 0;
  endtask
  initial begin
    test_reset();
    test_level();
    test_count();
    test_backpressure();
    test_addr_inc();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
